// File: rtl/btb_pkg.sv
// btb_pkg: shared types for the BTB update issuer and its ring buffer.
// Holds the update record, the issuer FSM state enum and the default PC width.
package btb_pkg;

    localparam int BTB_PC_W = 32;

    typedef struct packed {
        logic [BTB_PC_W-1:0] pc;
        logic [BTB_PC_W-1:0] target;
        logic                taken;
    } btb_update_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } issuer_state_t;

endpackage

// File: rtl/btb_update_issuer_if.sv
// btb_update_issuer_if: pipeline update handshake plus BTB write/resp bus.
// master = issuer side (drives upd_ready, btb_*), slave = pipeline + BTB side.
interface btb_update_issuer_if
    import btb_pkg::*;
#(
    parameter int PC_W = BTB_PC_W
) ();

    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            upd_ready;
    logic            btb_write;
    logic [PC_W-1:0] btb_pc;
    logic [PC_W-1:0] btb_target;
    logic            btb_taken;
    logic            btb_resp;

    modport master (
        input  upd_valid, upd_pc, upd_target, upd_taken, btb_resp,
        output upd_ready, btb_write, btb_pc, btb_target, btb_taken
    );

    modport slave (
        output upd_valid, upd_pc, upd_target, upd_taken, btb_resp,
        input  upd_ready, btb_write, btb_pc, btb_target, btb_taken
    );

endinterface

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: ring buffer of pending BTB updates.
// Ports: push/din write at wr_ptr, pop advances rd_ptr, head = oldest entry, count = occupancy.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = btb_update_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Pointers wrap naturally; only count tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/btb_update_issuer.sv
// btb_update_issuer: buffers resolved-branch updates and issues each as a one-cycle
// BTB write, retiring on resp or on timeout. Ports: clk, rst_n, bus (master), count, timeout_err.
module btb_update_issuer
    import btb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PC_W    = BTB_PC_W,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    btb_update_issuer_if.master    bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err
);

    localparam int            CW    = $clog2(DEPTH) + 1;
    localparam int            WW    = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    issuer_state_t state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          terr_q, terr_d;
    logic          push, pop, active;
    btb_update_t   din, head;

    // Ready depends only on registered count, so a pop cannot free a full slot early.
    assign bus.upd_ready = (count != CW'(DEPTH));
    assign push          = bus.upd_valid && bus.upd_ready;
    assign din           = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken};

    btb_update_fifo #(
        .DEPTH (DEPTH),
        .T     (btb_update_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    // resp outside WAIT is a protocol violation and falls through untouched.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
        pop     = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                if (count != '0) state_d = REQ;
            end
            state_q == REQ: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            state_q == WAIT: begin
                if (bus.btb_resp || wcnt_q == WLAST) begin
                    pop = 1'b1;
                    if (!bus.btb_resp) terr_d = 1'b1;
                    // count is pre-pop here, so > 1 means entries remain.
                    state_d = (count > CW'(1)) ? REQ : IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
        end
    end

    assign active         = (state_q == REQ) || (state_q == WAIT);
    assign bus.btb_write  = (state_q == REQ);
    assign bus.btb_pc     = active ? head.pc     : '0;
    assign bus.btb_target = active ? head.target : '0;
    assign bus.btb_taken  = active ? head.taken  : 1'b0;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_btb_update_issuer.sv
// tb_btb_update_issuer: scoreboard bench for btb_update_issuer.
// Directed phases plus random traffic against an event-level occupancy/retire model.
module tb_btb_update_issuer;
    import btb_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic                   timeout_err;

    btb_update_issuer_if #(.PC_W(PC_W)) bus ();

    btb_update_issuer #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .count       (count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment knobs
    bit          resp_en = 1'b1;
    bit          force_resp = 1'b0;
    bit          drop_en = 1'b0;
    bit          rand_drop = 1'b0;
    logic [31:0] drop_pc = '0;
    bit          mon_on = 1'b0;

    // Reference model state
    btb_update_t sbq[$];
    btb_update_t cur;
    btb_update_t e;
    int          outstanding = 0;
    int          k = 0;
    bit          waiting = 1'b0;
    bit          terr_m = 1'b0;
    bit          prev_write = 1'b0;
    bit          acc, ret;
    int          last_wcyc = -1;
    int          gaps[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int waited, input int limit);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: waited %0d cycles, limit %0d", name, waited, limit);
    endtask

    // BTB model: answers one cycle after seeing a write, unless told to stay silent.
    initial begin
        bit w, f;
        bus.btb_resp = 1'b0;
        forever begin
            @(negedge clk);
            w = resp_en && bus.btb_write
                && !(drop_en && bus.btb_pc == drop_pc)
                && !(rand_drop && $urandom_range(0, 7) == 0);
            f = force_resp;
            @(posedge clk);
            #1;
            bus.btb_resp = w || f;
        end
    end

    // Monitor: compares every cycle, then advances the model across the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                chk("count", count, outstanding);
                chk("upd_ready", bus.upd_ready, outstanding != DEPTH);
                chk("timeout_err", timeout_err, terr_m);
                if (bus.btb_write) begin
                    chk("write_spacing", prev_write, 0);
                    if (sbq.size() == 0) begin
                        fail("write_unexpected", 0, 0);
                        cur = '0;
                    end else begin
                        e = sbq.pop_front();
                        chk("wr_pc", bus.btb_pc, e.pc);
                        chk("wr_target", bus.btb_target, e.target);
                        chk("wr_taken", bus.btb_taken, e.taken);
                        cur = e;
                    end
                    if (last_wcyc >= 0) gaps.push_back(cyc - last_wcyc);
                    last_wcyc = cyc;
                    waiting = 1'b1;
                    k = 0;
                end else if (waiting) begin
                    k++;
                    chk("wait_pc", bus.btb_pc, cur.pc);
                    chk("wait_taken", bus.btb_taken, cur.taken);
                end else begin
                    chk("idle_pc", bus.btb_pc, 0);
                    chk("idle_target", bus.btb_target, 0);
                    chk("idle_taken", bus.btb_taken, 0);
                end
                acc = bus.upd_valid && (outstanding != DEPTH);
                ret = waiting && k >= 1 && (bus.btb_resp || k == TIMEOUT);
                if (acc) begin
                    sbq.push_back(btb_update_t'{pc: bus.upd_pc, target: bus.upd_target,
                                                taken: bus.upd_taken});
                    outstanding++;
                end
                if (ret) begin
                    outstanding--;
                    waiting = 1'b0;
                    if (!bus.btb_resp) terr_m = 1'b1;
                end
                prev_write = bus.btb_write;
                if (!rst_n) begin
                    outstanding = 0;
                    waiting = 1'b0;
                    terr_m = 1'b0;
                    sbq.delete();
                    prev_write = 1'b0;
                    last_wcyc = -1;
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        int n = 0;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = tk;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.upd_ready && n < 200);
        if (!bus.upd_ready) fail("push_ready", n, 200);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (outstanding != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (outstanding != 0) fail("drain", n, limit);
        repeat (2) @(negedge clk);
        sync();
    endtask

    task automatic wait_write(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.btb_write && n < limit);
        if (!bus.btb_write) fail("wait_write", n, limit);
    endtask

    task automatic random_traffic(input int n_upd);
        for (int i = 0; i < n_upd; i++) begin
            push($urandom, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) sync();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;

        // Reset then idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_write", bus.btb_write, 0);
        chk("rst_pc", bus.btb_pc, 0);
        chk("rst_target", bus.btb_target, 0);
        chk("rst_taken", bus.btb_taken, 0);
        chk("rst_ready", bus.upd_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_terr", timeout_err, 0);
        mon_on = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_no_write", bus.btb_write, 0);
        end

        // Single update latency
        sync();
        push(32'h100, 32'h200, 1'b1);
        @(negedge clk);
        chk("single_c1_write", bus.btb_write, 0);
        @(negedge clk);
        chk("single_c2_write", bus.btb_write, 1);
        chk("single_c2_pc", bus.btb_pc, 32'h100);
        chk("single_c2_target", bus.btb_target, 32'h200);
        chk("single_c2_taken", bus.btb_taken, 1);
        @(negedge clk);
        chk("single_c3_write", bus.btb_write, 0);
        chk("single_c3_count", count, 1);
        @(negedge clk);
        chk("single_c4_count", count, 0);
        sync();

        // Fill and backpressure
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 1'(i));
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h1010;
        bus.upd_target = 32'h2010;
        bus.upd_taken  = 1'b0;
        @(negedge clk);
        chk("fill_count", count, 4);
        chk("fill_ready", bus.upd_ready, 0);
        sync();
        force_resp = 1'b1;
        @(negedge clk);
        chk("fill_held_ready", bus.upd_ready, 0);
        sync();
        force_resp = 1'b0;
        resp_en = 1'b1;
        gaps.delete();
        @(negedge clk);
        chk("fill_resp_ready", bus.upd_ready, 0);
        sync();
        @(negedge clk);
        chk("fill_after_pop_ready", bus.upd_ready, 1);
        sync();
        bus.upd_valid = 1'b0;
        drain(300);
        chk("fill_gap_count", gaps.size(), 4);
        for (int i = 1; i < 4; i++)
            chk("fill_gap", (gaps.size() > i) ? gaps[i] : -1, 2);

        // Steady push+pop at count=2, wrapping pointers twice
        push(32'h3000, 32'h4000, 1'b1);
        push(32'h3004, 32'h4004, 1'b0);
        for (int i = 2; i < 8; i++) begin
            wait_write(50);
            chk("wrap_count", count, 2);
            sync();
            push(32'h3000 + 32'(i * 4), 32'h4000 + 32'(i * 4), 1'(i));
        end
        drain(300);

        // Random traffic, BTB always answers
        random_traffic(30);
        drain(1000);

        // Timeout on one entry
        drop_pc = 32'h40;
        drop_en = 1'b1;
        push(32'h40, 32'h80, 1'b1);
        push(32'h44, 32'h88, 1'b0);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_set", timeout_err, 1);
        chk("timeout_next_pending", count, 1);
        drain(300);
        drop_en = 1'b0;
        chk("timeout_sticky", timeout_err, 1);

        // Late resp while idle
        resp_en = 1'b0;
        force_resp = 1'b1;
        sync();
        force_resp = 1'b0;
        @(negedge clk);
        chk("late_resp_seen", bus.btb_resp, 1);
        chk("late_count", count, 0);
        @(negedge clk);
        chk("late_count2", count, 0);
        chk("late_write", bus.btb_write, 0);
        sync();

        // Reset mid-WAIT with three queued
        push(32'h300, 32'h600, 1'b1);
        push(32'h304, 32'h604, 1'b0);
        push(32'h308, 32'h608, 1'b1);
        @(negedge clk);
        chk("midrst_count", count, 3);
        sync();
        rst_n = 1'b0;
        force_resp = 1'b1;
        sync();
        rst_n = 1'b1;
        force_resp = 1'b0;
        @(negedge clk);
        chk("midrst_count0", count, 0);
        chk("midrst_write", bus.btb_write, 0);
        chk("midrst_pc", bus.btb_pc, 0);
        chk("midrst_terr", timeout_err, 0);
        repeat (4) begin
            @(negedge clk);
            chk("midrst_idle_write", bus.btb_write, 0);
            chk("midrst_idle_count", count, 0);
        end
        resp_en = 1'b1;
        sync();

        // Random traffic with occasional silent BTB
        rand_drop = 1'b1;
        random_traffic(25);
        drain(2000);
        rand_drop = 1'b0;
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
